hub75_row_rx: RTL and testbench
===============================

HUB75_ROW_RX -- requirements
Module: hub75_row_rx

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state advances on its rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports A, B, C, D  in  1 each  row address; row = {D,C,B,A}.
REQ-004 SHALL have ports R0, G0, B0, R1, G1, B1  in  1 each  upper/lower half pixel colour.
REQ-005 SHALL have port OE  in  1  high = column sample valid this cycle.
REQ-006 SHALL have port LAT  in  1  rising edge = row commit.
REQ-007 SHALL have port out_valid  out  1  stream beat valid.
REQ-008 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-009 SHALL have ports out_row  out  4, out_col  out  6, out_rgb  out  6 ({R0,G0,B0,R1,G1,B1}), out_last  out  1 (col 63).
REQ-010 SHALL have ports short_err, long_err, drop_err  out  1 each  single-cycle error pulses.
REQ-011 SHALL have port err_cnt  out  24  {drop,long,short} 8-bit counters, MSB first.

Function
REQ-012 SHALL hold two 64x6 row buffers, each in state FREE, FILLING, FULL or DRAINING.
REQ-013 SHALL, each cycle with OE=1 and no LAT edge, write the 6 colour inputs at column index cnt of the FILLING buffer and increment cnt (7 bits, saturating at 64).
REQ-014 SHALL discard samples arriving with cnt=64 and mark the current row as long.
REQ-015 SHALL detect a LAT edge as LAT=1 with registered previous LAT=0; OE is ignored in that cycle.
REQ-016 SHALL, on a LAT edge with cnt<64, discard the row, pulse short_err for one cycle, clear cnt, and reuse the same buffer.
REQ-017 SHALL, on a LAT edge with cnt=64 and the other buffer FREE, mark the buffer FULL with row {D,C,B,A} sampled in the edge cycle, move FILLING to the other buffer, and clear cnt; long_err pulses in the same cycle if the row was marked long.
REQ-018 SHALL, on a LAT edge with cnt=64 and no FREE buffer, discard the row, pulse drop_err, and clear cnt.
REQ-019 SHALL assert out_valid in the cycle after a buffer becomes FULL when no buffer is DRAINING; the buffer becomes DRAINING at that point.
REQ-020 SHALL present beats in column order 0..63; a beat transfers when out_valid and out_ready are both 1.
REQ-021 SHALL hold out_row, out_col, out_rgb and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on transfer of the out_last beat, mark the buffer FREE; if the other buffer is FULL, it SHALL be presented with no bubble cycle, otherwise out_valid=0.
REQ-023 SHALL drain committed rows in commit order.
REQ-024 SHALL permit a commit and a drain completion in the same cycle, with the freed buffer available from the next cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force all buffers FREE, cnt=0, the registered LAT to 0, and out_valid, out_last and all *_err outputs to 0; out_row, out_col, out_rgb and err_cnt SHALL reset to 0.
REQ-026 SHALL, on reset mid-row or mid-drain, discard all partial and committed data; no beats from before reset SHALL appear after reset.
REQ-027 SHALL, when rst_n is released with LAT already high, not treat the first cycle as a LAT edge.

Configuration
REQ-028 SHALL include the err_cnt counters only when HUB75_RX_ERRCNT_EN is defined.
REQ-029 With HUB75_RX_ERRCNT_EN defined, each counter SHALL increment on its error pulse and saturate at 255.
REQ-030 Without HUB75_RX_ERRCNT_EN, err_cnt SHALL be constant 0; the error pulses SHALL be unaffected.

Verification
REQ-031 64 OE cycles with rgb=col[5:0], {D,C,B,A}=5, LAT edge, out_ready=1 -> out_valid rises 1 cycle after the edge; 64 beats with out_row=5, out_col=0..63, out_rgb=col, out_last only at col 63.
REQ-032 out_ready=0 with rows 1 and 2 committed, then a third full row + LAT -> drop_err pulse, err_cnt[23:16]=1; after out_ready=1, exactly rows 1 then 2 are output, back-to-back with no bubble.
REQ-033 40 OE cycles, then LAT -> short_err pulse, err_cnt[7:0]=1, no beats; the next full row is output correctly.
REQ-034 70 OE cycles, then LAT -> long_err pulse; beats carry the first 64 samples only.
REQ-035 rst_n low at drain beat 20 -> out_valid=0 immediately; after release, no beats until a new full row is committed.
REQ-036 out_ready toggling every cycle during a drain -> 64 in-order beats; outputs stable during stalls.

Source files
------------

// File: rtl/hub75_row_rx.sv
// hub75_row_rx: HUB75 row receiver, two 64x6 row buffers drained as a valid/ready beat stream.
// Define HUB75_RX_ERRCNT_EN to build the saturating {drop,long,short} counters on err_cnt.
`timescale 1ns/1ps
module hub75_row_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        R0,
  input  logic        G0,
  input  logic        B0,
  input  logic        R1,
  input  logic        G1,
  input  logic        B1,
  input  logic        OE,
  input  logic        LAT,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_row,
  output logic [5:0]  out_col,
  output logic [5:0]  out_rgb,
  output logic        out_last,
  output logic        short_err,
  output logic        long_err,
  output logic        drop_err,
  output logic [23:0] err_cnt
);

  typedef enum logic [1:0] {
    B_FREE,
    B_FILL,
    B_FULL,
    B_DRAIN
  } bst_t;

  bst_t       r_bst [2];
  bst_t       w_bst_nxt [2];
  logic       r_fill;
  logic       r_fvld;
  logic       w_fill_nxt;
  logic       w_fvld_nxt;
  logic [6:0] r_cnt;
  logic       r_lat;
  logic       r_arm;
  logic       r_long;
  logic [3:0] r_row [2];
  logic [5:0] r_mem [2][64];
  logic       r_drn;

  logic       w_edge;
  logic       w_full;
  logic       w_free0;
  logic       w_free1;
  logic       w_grab;
  logic       w_gidx;
  logic       w_tgt;
  logic       w_wr;
  logic       w_oth;
  logic       w_commit;
  logic       w_short;
  logic       w_drop;
  logic       w_xfer;
  logic       w_done;
  logic       w_idle;
  logic       w_pend;
  logic       w_pidx;
  logic       w_start;
  logic [3:0] w_prow;
  logic [5:0] w_ncol;
  logic [5:0] w_rgb;

  // r_arm masks a LAT that is already high when reset releases
  assign w_edge   = LAT & ~r_lat & r_arm;
  assign w_full   = (r_cnt == 7'd64);
  assign w_free0  = (r_bst[0] == B_FREE);
  assign w_free1  = (r_bst[1] == B_FREE);
  assign w_grab   = ~r_fvld & (r_cnt == 7'd0) & (w_free0 | w_free1);
  assign w_gidx   = ~w_free0;
  assign w_tgt    = r_fvld ? r_fill : w_gidx;
  assign w_wr     = OE & ~w_edge & ~w_full & (r_fvld | w_grab);
  assign w_oth    = ~r_fill;
  assign w_commit = w_edge & w_full & r_fvld;
  assign w_short  = w_edge & ~w_full;
  assign w_drop   = w_edge & w_full & ~r_fvld;
  assign w_xfer   = out_valid & out_ready;
  assign w_done   = w_xfer & out_last;
  assign w_idle   = ~out_valid | w_done;
  assign w_start  = w_idle & w_pend;
  assign w_prow   = w_commit ? {D, C, B, A} : r_row[w_pidx];
  assign w_ncol   = out_col + 6'd1;
  assign w_rgb    = {R0, G0, B0, R1, G1, B1};

  // At most one row waits behind the draining one, so this is one-hot
  always_comb begin
    w_pend = 1'b0;
    w_pidx = 1'b0;
    unique case (1'b1)
      w_commit: begin
        w_pend = 1'b1;
        w_pidx = r_fill;
      end
      (r_bst[0] == B_FULL): begin
        w_pend = 1'b1;
        w_pidx = 1'b0;
      end
      (r_bst[1] == B_FULL): begin
        w_pend = 1'b1;
        w_pidx = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_bst_nxt[0] = r_bst[0];
    w_bst_nxt[1] = r_bst[1];
    w_fill_nxt   = r_fill;
    w_fvld_nxt   = r_fvld;
    if (w_grab) begin
      w_bst_nxt[w_gidx] = B_FILL;
      w_fill_nxt        = w_gidx;
      w_fvld_nxt        = 1'b1;
    end
    if (w_done) begin
      w_bst_nxt[r_drn] = B_FREE;
    end
    if (w_commit) begin
      w_bst_nxt[r_fill] = B_FULL;
      if (r_bst[w_oth] == B_FREE) begin
        w_bst_nxt[w_oth] = B_FILL;
        w_fill_nxt       = w_oth;
      end else begin
        w_fvld_nxt = 1'b0;
      end
    end
    if (w_start) begin
      w_bst_nxt[w_pidx] = B_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bst[0] <= B_FREE;
      r_bst[1] <= B_FREE;
      r_fill   <= 1'b0;
      r_fvld   <= 1'b0;
      r_row[0] <= 4'd0;
      r_row[1] <= 4'd0;
    end else begin
      r_bst[0] <= w_bst_nxt[0];
      r_bst[1] <= w_bst_nxt[1];
      r_fill   <= w_fill_nxt;
      r_fvld   <= w_fvld_nxt;
      if (w_commit) begin
        r_row[r_fill] <= {D, C, B, A};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 7'd0;
      r_lat  <= 1'b0;
      r_arm  <= 1'b0;
      r_long <= 1'b0;
    end else begin
      r_lat <= LAT;
      r_arm <= 1'b1;
      if (w_edge) begin
        r_cnt  <= 7'd0;
        r_long <= 1'b0;
      end else if (OE) begin
        if (w_full) begin
          r_long <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 7'd1;
        end
      end
    end
  end

  // Samples with no buffer to land in still advance cnt so the row drops
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_tgt][r_cnt[5:0]] <= w_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_err <= 1'b0;
      long_err  <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      short_err <= w_short;
      long_err  <= w_commit & r_long;
      drop_err  <= w_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= 4'd0;
      out_col   <= 6'd0;
      out_rgb   <= 6'd0;
      r_drn     <= 1'b0;
    end else if (w_start) begin
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_row   <= w_prow;
      out_col   <= 6'd0;
      out_rgb   <= r_mem[w_pidx][6'd0];
      r_drn     <= w_pidx;
    end else if (w_done) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_xfer) begin
      out_col  <= w_ncol;
      out_rgb  <= r_mem[r_drn][w_ncol];
      out_last <= (w_ncol == 6'd63);
    end
  end

`ifdef HUB75_RX_ERRCNT_EN
  logic [7:0] r_cs;
  logic [7:0] r_cl;
  logic [7:0] r_cd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs <= 8'd0;
      r_cl <= 8'd0;
      r_cd <= 8'd0;
    end else begin
      if (w_short && r_cs != 8'hff) r_cs <= r_cs + 8'd1;
      if (w_commit && r_long && r_cl != 8'hff) r_cl <= r_cl + 8'd1;
      if (w_drop && r_cd != 8'hff) r_cd <= r_cd + 8'd1;
    end
  end

  assign err_cnt = {r_cd, r_cl, r_cs};
`else
  assign err_cnt = 24'd0;
`endif

endmodule

// File: tb/tb_hub75_row_rx.sv
// tb_hub75_row_rx: random HUB75 rows against a row-level model; a monitor pops
// expected beats and error pulses from queues and checks them as the DUT emits them.
`timescale 1ns/1ps
module tb_hub75_row_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A, B, C, D;
  logic R0, G0, B0, R1, G1, B1;
  logic OE, LAT, out_ready;
  logic out_valid, out_last;
  logic short_err, long_err, drop_err;
  logic [3:0] out_row;
  logic [5:0] out_col, out_rgb;
  logic [23:0] err_cnt;

  hub75_row_rx dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .OE(OE), .LAT(LAT),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_rgb(out_rgb),
    .out_last(out_last),
    .short_err(short_err), .long_err(long_err), .drop_err(drop_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
    logic [5:0] rgb;
    logic       last;
  } beat_t;

  beat_t      bq[$];
  logic [2:0] eq[$];
  int vectors = 0;
  int miscompares = 0;
  int held = 0;
  int rmode = 0;
  int n_short = 0, n_long = 0, n_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  function automatic logic [23:0] exp_cnt();
`ifdef HUB75_RX_ERRCNT_EN
    return {sat(n_drop), sat(n_long), sat(n_short)};
`else
    return 24'd0;
`endif
  endfunction

  // ready pattern: 0 always, 1 random, 2 never, 3 toggle
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        2: out_ready = 1'b0;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  logic        pv, pr, nb;
  logic [16:0] pb;

  initial begin
    logic [16:0] cur;
    logic [2:0]  ev;
    beat_t       e;
    pv = 0; pr = 0; nb = 0; pb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        nb = 0;
      end else begin
        cur = {out_row, out_col, out_rgb, out_last};
        if (nb) begin
          chk("no_bubble", {31'd0, out_valid}, 1);
          nb = 0;
        end
        if (pv && !pr) begin
          chk("stall_valid", {31'd0, out_valid}, 1);
          chk("stall_data", {15'd0, cur}, {15'd0, pb});
        end
        if (out_valid && out_ready) begin
          if (bq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t",
                     cur, $time);
          end else begin
            e = bq.pop_front();
            chk("beat", {15'd0, cur}, {15'd0, e});
            if (e.last) begin
              held--;
              if (bq.size() > 0) nb = 1;
            end
          end
        end
        ev = {drop_err, long_err, short_err};
        if (ev != 3'd0) begin
          if (eq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_err: got %0b expected none at %0t",
                     ev, $time);
          end else begin
            chk("err_pulse", {29'd0, ev}, {29'd0, eq.pop_front()});
          end
        end
        pv = out_valid;
        pr = out_ready;
        pb = cur;
      end
    end
  end

  // One row: n OE samples (optional idle gaps), then a LAT edge with row addr
  task automatic send_row(input int n, input logic [3:0] row,
                          input bit colpat, input bit gaps);
    logic [5:0] s[$];
    logic [5:0] v;
    bit acc;
    int k, h0;
    beat_t b;
    acc = 0;
    k = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      OE = 0;
      LAT = 0;
    end
    while (k < n) begin
      @(posedge clk);
      #1;
      {D, C, B, A} = 4'($urandom);
      if (gaps && $urandom_range(3) == 0) begin
        OE = 0;
        {R0, G0, B0, R1, G1, B1} = 6'($urandom);
      end else begin
        if (k == 0) acc = (held < 2);
        v = colpat ? k[5:0] : 6'($urandom);
        {R0, G0, B0, R1, G1, B1} = v;
        OE = 1;
        s.push_back(v);
        k++;
      end
    end
    @(posedge clk);
    #1;
    LAT = 1;
    OE = 1'($urandom);
    {D, C, B, A} = row;
    {R0, G0, B0, R1, G1, B1} = 6'($urandom);
    h0 = held;
    if (n < 64) begin
      eq.push_back(3'b001);
      n_short++;
    end else if (acc) begin
      for (int i = 0; i < 64; i++) begin
        b.row = row;
        b.col = i[5:0];
        b.rgb = s[i];
        b.last = (i == 63);
        bq.push_back(b);
      end
      held++;
      if (n > 64) begin
        eq.push_back(3'b010);
        n_long++;
      end
      if (h0 == 0) chk("idle_before_commit", {31'd0, out_valid}, 0);
    end else begin
      eq.push_back(3'b100);
      n_drop++;
    end
    @(posedge clk);
    #1;
    LAT = 0;
    OE = 0;
    if (n >= 64 && acc && h0 == 0)
      chk("valid_rise", {31'd0, out_valid}, 1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && (bq.size() != 0 || held != 0); c++)
      @(posedge clk);
    chk("drain_left", bq.size(), 0);
    #1;
  endtask

  task automatic clear_model();
    bq.delete();
    eq.delete();
    held = 0;
    n_short = 0;
    n_long = 0;
    n_drop = 0;
  endtask

  initial begin
    bit found;
    int r, n;
    {A, B, C, D} = '0;
    {R0, G0, B0, R1, G1, B1} = '0;
    OE = 0;
    LAT = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_errs", {29'd0, drop_err, long_err, short_err}, 0);
    chk("rst_data", {16'd0, out_row, out_col, out_rgb}, 0);
    chk("rst_errcnt", {8'd0, err_cnt}, 0);
    rst_n = 1;

    rmode = 0;
    send_row(64, 4'd5, 1, 0);
    wait_drain();

    rmode = 2;
    send_row(64, 4'd1, 0, 0);
    send_row(64, 4'd2, 0, 0);
    send_row(64, 4'd3, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("errcnt_drop", {8'd0, err_cnt}, {8'd0, exp_cnt()});
    rmode = 0;
    wait_drain();

    send_row(40, 4'd6, 0, 0);
    send_row(64, 4'd7, 1, 1);
    wait_drain();
    chk("errcnt_short", {8'd0, err_cnt}, {8'd0, exp_cnt()});

    send_row(70, 4'd9, 0, 1);
    wait_drain();
    chk("errcnt_long", {8'd0, err_cnt}, {8'd0, exp_cnt()});

    rmode = 3;
    send_row(64, 4'd11, 0, 1);
    wait_drain();

    rmode = 0;
    send_row(64, 4'd12, 0, 0);
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_col == 6'd20) found = 1;
    end
    chk("reach_beat20", {31'd0, found}, 1);
    #1;
    rst_n = 0;
    clear_model();
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 0);
    chk("rst_mid_last", {31'd0, out_last}, 0);
    LAT = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    LAT = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, out_valid}, 0);
    chk("post_rst_errcnt", {8'd0, err_cnt}, 0);
    send_row(64, 4'd13, 0, 0);
    wait_drain();

    for (int i = 0; i < 25; i++) begin
      rmode = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 6) n = 64;
      else if (r < 8) n = $urandom_range(65, 70);
      else n = $urandom_range(20, 63);
      send_row(n, 4'($urandom), 0, 1'($urandom));
    end
    rmode = 0;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("errcnt_final", {8'd0, err_cnt}, {8'd0, exp_cnt()});
    chk("err_left", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
